// File: rtl/encoder_pkg.sv
// Shared constants for the quadrature encoder bank: decode modes, decoder FSM states
// and the Gray-code step classifier used by the x4 decoder.
package encoder_pkg;

   localparam int MODE_X1 = 0;
   localparam int MODE_X4 = 1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_A    = 2'd1,
      ST_WAIT_B    = 2'd2,
      ST_WAIT_IDLE = 2'd3
   } dec_state_t;

   // Returns {inc, dec} for one {A,B} transition; CW order is 11->01->00->10->11.
   function automatic logic [1:0] gray_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
      logic [1:0] step;
      step = 2'b00;
      case ({prev_ab, cur_ab})
         4'b1101, 4'b0100, 4'b0010, 4'b1011: step = 2'b10;
         4'b1110, 4'b1000, 4'b0001, 4'b0111: step = 2'b01;
         default:                            step = 2'b00;
      endcase
      return step;
   endfunction

endpackage

// File: rtl/quad_encoder_channel.sv
// One encoder channel: input synchronisers, glitch filters, x1/x4 rotation decoder,
// position counter and push-button press/release/long-press detection.
module quad_encoder_channel
   import encoder_pkg::*;
#(
   parameter int COUNT_WIDTH   = 16,
   parameter int FILTER_CYCLES = 16,
   parameter int MODE          = MODE_X1,
   parameter int WRAP          = 1,
   parameter int LONG_CYCLES   = 10_000_000
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   AsyncA_i,
   input  logic                   AsyncB_i,
   input  logic                   AsyncS_i,
   input  logic                   Clear_i,
   output logic [COUNT_WIDTH-1:0] Count_o,
   output logic                   Increment_o,
   output logic                   Decrement_o,
   output logic                   Error_o,
   output logic                   ButtonPress_o,
   output logic                   ButtonRelease_o,
   output logic                   LongPress_o,
   output logic                   ButtonState_o
);

   // Bit order {S, B, A}; S is inverted so 1 means pressed.
   localparam logic [2:0] RST_LEVEL = 3'b011;
   localparam int         HW        = $clog2(LONG_CYCLES + 1);

   logic [2:0]             r_meta, r_sync;
   logic [2:0]             w_filt;
   logic [1:0]             w_ab, r_ab_prev, w_gray;
   logic                   w_inc, w_dec, w_err, w_s;
   dec_state_t             r_state, w_state_next;
   logic [COUNT_WIDTH-1:0] r_count;
   logic [HW-1:0]          r_hold;
   logic                   r_inc, r_dec, r_err, r_press, r_release, r_long, r_s_prev;

   always_ff @(posedge Clock or negedge Reset)
      if (!Reset) begin
         r_meta <= RST_LEVEL;
         r_sync <= RST_LEVEL;
      end else begin
         r_meta <= {~AsyncS_i, AsyncB_i, AsyncA_i};
         r_sync <= r_meta;
      end

   generate
      if (FILTER_CYCLES == 0) begin : g_bypass
         assign w_filt = r_sync;
      end else begin : g_filter
         localparam int FW = $clog2(FILTER_CYCLES + 1);
         logic [2:0]    r_filt;
         logic [FW-1:0] r_fcnt [3];

         // A return to the accepted level restarts the stability count.
         always_ff @(posedge Clock or negedge Reset)
            if (!Reset) begin
               r_filt <= RST_LEVEL;
               for (int i = 0; i < 3; i++) r_fcnt[i] <= '0;
            end else begin
               for (int i = 0; i < 3; i++) begin
                  if (r_sync[i] == r_filt[i]) begin
                     r_fcnt[i] <= '0;
                  end else if (r_fcnt[i] == FW'(FILTER_CYCLES - 1)) begin
                     r_filt[i] <= r_sync[i];
                     r_fcnt[i] <= '0;
                  end else begin
                     r_fcnt[i] <= r_fcnt[i] + 1'b1;
                  end
               end
            end

         assign w_filt = r_filt;
      end
   endgenerate

   assign w_ab = {w_filt[0], w_filt[1]};
   assign w_s  = w_filt[2];

   always_ff @(posedge Clock or negedge Reset)
      if (!Reset) r_state <= ST_IDLE;
      else        r_state <= w_state_next;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:
            case (w_ab)
               2'b01:   w_state_next = ST_WAIT_A;
               2'b10:   w_state_next = ST_WAIT_B;
               2'b00:   w_state_next = ST_WAIT_IDLE;
               default: w_state_next = ST_IDLE;
            endcase
         ST_WAIT_A:
            case (w_ab)
               2'b00:   w_state_next = ST_WAIT_IDLE;
               2'b11:   w_state_next = ST_IDLE;
               2'b10:   w_state_next = ST_WAIT_B;
               default: w_state_next = ST_WAIT_A;
            endcase
         ST_WAIT_B:
            case (w_ab)
               2'b00:   w_state_next = ST_WAIT_IDLE;
               2'b11:   w_state_next = ST_IDLE;
               2'b01:   w_state_next = ST_WAIT_A;
               default: w_state_next = ST_WAIT_B;
            endcase
         default:
            if (w_ab == 2'b11) w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_gray = gray_step(r_ab_prev, w_ab);
      w_err  = ((r_ab_prev ^ w_ab) == 2'b11);
      w_inc  = 1'b0;
      w_dec  = 1'b0;
      if (MODE == MODE_X4) begin
         w_inc = w_gray[1];
         w_dec = w_gray[0];
      end else begin
         w_inc = (r_state == ST_WAIT_A) && (w_ab == 2'b00);
         w_dec = (r_state == ST_WAIT_B) && (w_ab == 2'b00);
      end
   end

   always_ff @(posedge Clock or negedge Reset)
      if (!Reset) begin
         r_ab_prev <= 2'b11;
         r_inc     <= 1'b0;
         r_dec     <= 1'b0;
         r_err     <= 1'b0;
         r_count   <= '0;
      end else begin
         r_ab_prev <= w_ab;
         r_inc     <= w_inc;
         r_dec     <= w_dec;
         r_err     <= w_err;
         if (Clear_i)
            r_count <= '0;
         else if (w_inc)
            r_count <= (WRAP == 0 && (&r_count)) ? r_count : r_count + 1'b1;
         else if (w_dec)
            r_count <= (WRAP == 0 && r_count == '0) ? r_count : r_count - 1'b1;
      end

   // Hold counter saturates at LONG_CYCLES so the long-press pulse fires once per press.
   always_ff @(posedge Clock or negedge Reset)
      if (!Reset) begin
         r_s_prev  <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_long    <= 1'b0;
         r_hold    <= '0;
      end else begin
         r_s_prev  <= w_s;
         r_press   <= w_s & ~r_s_prev;
         r_release <= ~w_s & r_s_prev;
         r_long    <= w_s && (r_hold == HW'(LONG_CYCLES - 1));
         if (!w_s)
            r_hold <= '0;
         else if (r_hold != HW'(LONG_CYCLES))
            r_hold <= r_hold + 1'b1;
      end

   assign Count_o         = r_count;
   assign Increment_o     = r_inc;
   assign Decrement_o     = r_dec;
   assign Error_o         = r_err;
   assign ButtonPress_o   = r_press;
   assign ButtonRelease_o = r_release;
   assign LongPress_o     = r_long;
   assign ButtonState_o   = r_s_prev;

endmodule

// File: rtl/quad_encoder_bank.sv
// Multi-channel quadrature encoder front end: one independent channel per encoder,
// with per-channel counters packed side by side on Count_o.
module quad_encoder_bank
   import encoder_pkg::*;
#(
   parameter int CHANNELS      = 2,
   parameter int COUNT_WIDTH   = 16,
   parameter int FILTER_CYCLES = 16,
   parameter int MODE          = MODE_X1,
   parameter int WRAP          = 1,
   parameter int LONG_CYCLES   = 10_000_000
) (
   input  logic                            Clock,
   input  logic                            Reset,
   input  logic [CHANNELS-1:0]             AsyncA_i,
   input  logic [CHANNELS-1:0]             AsyncB_i,
   input  logic [CHANNELS-1:0]             AsyncS_i,
   input  logic [CHANNELS-1:0]             Clear_i,
   output logic [CHANNELS*COUNT_WIDTH-1:0] Count_o,
   output logic [CHANNELS-1:0]             Increment_o,
   output logic [CHANNELS-1:0]             Decrement_o,
   output logic [CHANNELS-1:0]             Error_o,
   output logic [CHANNELS-1:0]             ButtonPress_o,
   output logic [CHANNELS-1:0]             ButtonRelease_o,
   output logic [CHANNELS-1:0]             LongPress_o,
   output logic [CHANNELS-1:0]             ButtonState_o
);

   for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
      quad_encoder_channel #(
         .COUNT_WIDTH   (COUNT_WIDTH),
         .FILTER_CYCLES (FILTER_CYCLES),
         .MODE          (MODE),
         .WRAP          (WRAP),
         .LONG_CYCLES   (LONG_CYCLES)
      ) u_ch (
         .Clock           (Clock),
         .Reset           (Reset),
         .AsyncA_i        (AsyncA_i[n]),
         .AsyncB_i        (AsyncB_i[n]),
         .AsyncS_i        (AsyncS_i[n]),
         .Clear_i         (Clear_i[n]),
         .Count_o         (Count_o[n*COUNT_WIDTH +: COUNT_WIDTH]),
         .Increment_o     (Increment_o[n]),
         .Decrement_o     (Decrement_o[n]),
         .Error_o         (Error_o[n]),
         .ButtonPress_o   (ButtonPress_o[n]),
         .ButtonRelease_o (ButtonRelease_o[n]),
         .LongPress_o     (LongPress_o[n]),
         .ButtonState_o   (ButtonState_o[n])
      );
   end

endmodule

// File: tb/tb_quad_encoder_bank.sv
// Directed bench: three bank instances (x1 wrap, x4 wrap, x4 saturate) share the same pin stimulus.
module tb_quad_encoder_bank;

   logic       Clock = 1'b0;
   logic       Reset;
   logic [1:0] A, B, S, Clr;

   logic [7:0] cnt [3];
   logic [1:0] inc [3];
   logic [1:0] dec [3];
   logic [1:0] err [3];
   logic [1:0] prs [3];
   logic [1:0] rel [3];
   logic [1:0] lng [3];
   logic [1:0] st  [3];

   always #5 Clock = ~Clock;

   quad_encoder_bank #(.CHANNELS(2), .COUNT_WIDTH(4), .FILTER_CYCLES(4), .MODE(0), .WRAP(1), .LONG_CYCLES(50)) u_x1 (
      .Clock(Clock), .Reset(Reset), .AsyncA_i(A), .AsyncB_i(B), .AsyncS_i(S), .Clear_i(Clr),
      .Count_o(cnt[0]), .Increment_o(inc[0]), .Decrement_o(dec[0]), .Error_o(err[0]),
      .ButtonPress_o(prs[0]), .ButtonRelease_o(rel[0]), .LongPress_o(lng[0]), .ButtonState_o(st[0]));

   quad_encoder_bank #(.CHANNELS(2), .COUNT_WIDTH(4), .FILTER_CYCLES(4), .MODE(1), .WRAP(1), .LONG_CYCLES(50)) u_x4 (
      .Clock(Clock), .Reset(Reset), .AsyncA_i(A), .AsyncB_i(B), .AsyncS_i(S), .Clear_i(Clr),
      .Count_o(cnt[1]), .Increment_o(inc[1]), .Decrement_o(dec[1]), .Error_o(err[1]),
      .ButtonPress_o(prs[1]), .ButtonRelease_o(rel[1]), .LongPress_o(lng[1]), .ButtonState_o(st[1]));

   quad_encoder_bank #(.CHANNELS(2), .COUNT_WIDTH(4), .FILTER_CYCLES(4), .MODE(1), .WRAP(0), .LONG_CYCLES(50)) u_sat (
      .Clock(Clock), .Reset(Reset), .AsyncA_i(A), .AsyncB_i(B), .AsyncS_i(S), .Clear_i(Clr),
      .Count_o(cnt[2]), .Increment_o(inc[2]), .Decrement_o(dec[2]), .Error_o(err[2]),
      .ButtonPress_o(prs[2]), .ButtonRelease_o(rel[2]), .LongPress_o(lng[2]), .ButtonState_o(st[2]));

   // Pulse tallies per instance/channel, sampled mid-cycle.
   int n_inc [3][2];
   int n_dec [3][2];
   int n_err [3][2];
   int n_prs [3][2];
   int n_rel [3][2];
   int n_lng [3][2];

   always @(negedge Clock)
      for (int d = 0; d < 3; d++)
         for (int c = 0; c < 2; c++) begin
            if (inc[d][c]) n_inc[d][c]++;
            if (dec[d][c]) n_dec[d][c]++;
            if (err[d][c]) n_err[d][c]++;
            if (prs[d][c]) n_prs[d][c]++;
            if (rel[d][c]) n_rel[d][c]++;
            if (lng[d][c]) n_lng[d][c]++;
         end

   int b_inc [3][2];
   int b_dec [3][2];
   int b_err [3][2];
   int b_prs [3][2];
   int b_rel [3][2];
   int b_lng [3][2];

   int n_vec  = 0;
   int n_fail = 0;

   task automatic snap();
      b_inc = n_inc; b_dec = n_dec; b_err = n_err;
      b_prs = n_prs; b_rel = n_rel; b_lng = n_lng;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic set_ab(input int ch, input logic a, input logic b);
      A[ch] = a;
      B[ch] = b;
      tick(10);
   endtask

   task automatic clear_all();
      Clr = 2'b11;
      tick(2);
      Clr = 2'b00;
      tick(1);
   endtask

   initial begin
      A = 2'b11; B = 2'b11; S = 2'b11; Clr = 2'b00;
      Reset = 1'b0;
      tick(3);
      check("rst_count_x1", 32'(cnt[0]), 32'h0);
      check("rst_outs_x1", 32'({inc[0], dec[0], err[0], prs[0], rel[0], lng[0], st[0]}), 32'h0);
      Reset = 1'b1;
      tick(10);

      // x1 decode: one full CW detent on ch0
      snap();
      set_ab(0, 1'b0, 1'b1);
      set_ab(0, 1'b0, 1'b0);
      set_ab(0, 1'b1, 1'b0);
      set_ab(0, 1'b1, 1'b1);
      check("x1_cw_inc", 32'(n_inc[0][0] - b_inc[0][0]), 32'd1);
      check("x1_cw_dec", 32'(n_dec[0][0] - b_dec[0][0]), 32'd0);
      check("x1_cw_cnt0", 32'(cnt[0][3:0]), 32'h1);
      check("x1_cw_cnt1", 32'(cnt[0][7:4]), 32'h0);
      check("x4_cw_inc", 32'(n_inc[1][0] - b_inc[1][0]), 32'd4);
      check("x4_cw_cnt0", 32'(cnt[1][3:0]), 32'h4);

      // Full CCW cycle on ch1: wrap vs saturate
      clear_all();
      snap();
      set_ab(1, 1'b1, 1'b0);
      set_ab(1, 1'b0, 1'b0);
      set_ab(1, 1'b0, 1'b1);
      set_ab(1, 1'b1, 1'b1);
      check("x4_ccw_dec", 32'(n_dec[1][1] - b_dec[1][1]), 32'd4);
      check("x4_ccw_cnt_wrap", 32'(cnt[1][7:4]), 32'hC);
      check("x4_ccw_ch0_idle", 32'(cnt[1][3:0]), 32'h0);
      check("sat_ccw_cnt", 32'(cnt[2][7:4]), 32'h0);
      check("sat_ccw_dec", 32'(n_dec[2][1] - b_dec[2][1]), 32'd4);
      check("x1_ccw_cnt_wrap", 32'(cnt[0][7:4]), 32'hF);

      // Glitch filter: 3-cycle pulse rejected, 5-cycle pulse accepted
      clear_all();
      snap();
      A[0] = 1'b0;
      tick(3);
      A[0] = 1'b1;
      tick(10);
      check("glitch3_inc", 32'(n_inc[1][0] - b_inc[1][0]), 32'd0);
      check("glitch3_cnt", 32'(cnt[1][3:0]), 32'h0);
      A[0] = 1'b0;
      tick(5);
      A[0] = 1'b1;
      tick(10);
      check("glitch5_inc", 32'(n_inc[1][0] - b_inc[1][0]), 32'd1);
      check("glitch5_dec", 32'(n_dec[1][0] - b_dec[1][0]), 32'd1);
      check("x1_abort_pulses", 32'((n_inc[0][0] - b_inc[0][0]) + (n_dec[0][0] - b_dec[0][0])), 32'd0);

      // Illegal double transition
      snap();
      set_ab(0, 1'b0, 1'b0);
      check("x4_err_pulse", 32'(n_err[1][0] - b_err[1][0]), 32'd1);
      check("x4_err_cnt", 32'(cnt[1][3:0]), 32'h0);
      check("x1_err_pulse", 32'(n_err[0][0] - b_err[0][0]), 32'd1);
      set_ab(0, 1'b1, 1'b1);
      check("x4_err_steps", 32'((n_inc[1][0] - b_inc[1][0]) + (n_dec[1][0] - b_dec[1][0])), 32'd0);

      // Clear coinciding with a step: sync(2) + filter(4) + output reg -> 7th edge
      snap();
      A[0] = 1'b0;
      tick(6);
      Clr[0] = 1'b1;
      tick(1);
      check("clr_step_pulse", 32'(inc[1][0]), 32'h1);
      Clr[0] = 1'b0;
      tick(5);
      check("clr_step_cnt", 32'(cnt[1][3:0]), 32'h0);
      check("clr_step_count", 32'(n_inc[1][0] - b_inc[1][0]), 32'd1);
      set_ab(0, 1'b1, 1'b1);
      check("x4_wrap_down", 32'(cnt[1][3:0]), 32'hF);
      check("sat_floor", 32'(cnt[2][3:0]), 32'h0);

      // Button: long hold then short hold
      snap();
      S[0] = 1'b0;
      tick(60);
      check("btn_state", 32'(st[0][0]), 32'h1);
      S[0] = 1'b1;
      tick(10);
      check("btn60_press", 32'(n_prs[0][0] - b_prs[0][0]), 32'd1);
      check("btn60_long", 32'(n_lng[0][0] - b_lng[0][0]), 32'd1);
      check("btn60_release", 32'(n_rel[0][0] - b_rel[0][0]), 32'd1);
      check("btn_state_off", 32'(st[0][0]), 32'h0);
      snap();
      S[0] = 1'b0;
      tick(30);
      S[0] = 1'b1;
      tick(10);
      check("btn30_press", 32'(n_prs[0][0] - b_prs[0][0]), 32'd1);
      check("btn30_long", 32'(n_lng[0][0] - b_lng[0][0]), 32'd0);
      check("btn30_release", 32'(n_rel[0][0] - b_rel[0][0]), 32'd1);

      // Reset while x1 decoder sits in WAIT_A
      set_ab(0, 1'b0, 1'b1);
      snap();
      Reset = 1'b0;
      A[0] = 1'b1;
      tick(3);
      check("rst_mid_cnt_x4", 32'(cnt[1]), 32'h0);
      check("rst_mid_cnt_x1", 32'(cnt[0]), 32'h0);
      check("rst_mid_outs_x4", 32'({inc[1], dec[1], err[1], prs[1], rel[1], lng[1], st[1]}), 32'h0);
      Reset = 1'b1;
      tick(15);
      check("rst_rel_x1_steps", 32'((n_inc[0][0] - b_inc[0][0]) + (n_err[0][0] - b_err[0][0])), 32'd0);
      check("rst_rel_x4_steps", 32'((n_dec[1][0] - b_dec[1][0]) + (n_err[1][0] - b_err[1][0])), 32'd0);
      check("rst_rel_cnt_x4", 32'(cnt[1]), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
